// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM encoding and default frame/timing constants,
// common to the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;
  localparam int unsigned DEFAULT_DATA_BITS    = 8;

endpackage

// File: rtl/uart_tx_engine_if.sv
// Host-side transmit handshake: start/data in, busy/done/serial line out.
interface uart_tx_engine_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS
) ();

  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 serial_out;

  modport master (
    output tx_start,
    output tx_data,
    input  tx_busy,
    input  tx_done,
    input  serial_out
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx_busy,
    output tx_done,
    output serial_out
  );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic bit_tick_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign bit_tick_o = enable_i && (count_q == LAST_CNT);

  // Clear wins over enable; the count wraps to zero on every bit boundary.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = bit_tick_o ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, one stop bit.
// Frame FSM, shift register and parity live here; bit timing comes from uart_baud_counter.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_engine_if.slave  bus
);

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic PARITY_INV = (PARITY_ODD != 0);

  uart_state_e          state_q, state_d;
  logic [BIT_W-1:0]     bitCnt_q, bitCnt_d;
  logic [DATA_BITS-1:0] shiftReg_q, shiftReg_d;
  logic                 parity_q, parity_d;
  logic                 serialOut_q, serialOut_d;
  logic                 done_q, done_d;
  logic                 bitTick;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (state_q == IDLE),
    .enable_i  (state_q != IDLE),
    .bit_tick_o(bitTick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      shiftReg_q  <= '0;
      parity_q    <= 1'b0;
      serialOut_q <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      shiftReg_q  <= shiftReg_d;
      parity_q    <= parity_d;
      serialOut_q <= serialOut_d;
      done_q      <= done_d;
    end
  end

  // Acceptance also covers the tx_done cycle, which is what makes frames back-to-back.
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    shiftReg_d = shiftReg_q;
    parity_d   = parity_q;
    case (state_q)
      IDLE: begin
        if (bus.tx_start) begin
          state_d    = START;
          bitCnt_d   = '0;
          shiftReg_d = bus.tx_data;
          parity_d   = (^bus.tx_data) ^ PARITY_INV;
        end
      end
      START: begin
        if (bitTick) state_d = DATA;
      end
      DATA: begin
        if (bitTick) begin
          shiftReg_d = shiftReg_q >> 1;
          if (bitCnt_q == LAST_BIT) begin
            bitCnt_d = '0;
            state_d  = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bitCnt_d = bitCnt_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bitTick) state_d = STOP;
      end
      STOP: begin
        if (bitTick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The line is registered, so its next value follows the next state rather than the current one.
  always_comb begin
    serialOut_d = 1'b1;
    case (state_d)
      START:   serialOut_d = 1'b0;
      DATA:    serialOut_d = shiftReg_d[0];
      PARITY:  serialOut_d = parity_d;
      default: serialOut_d = 1'b1;
    endcase
    done_d      = (state_q == STOP) && bitTick;
    bus.tx_busy = (state_q != IDLE);
  end

  assign bus.serial_out = serialOut_q;
  assign bus.tx_done    = done_q;

endmodule
